// File: rtl/pwm_duty_decoder.sv
// Measures period and high time of an asynchronous PWM input and reports duty = floor(H*2^DUTY_W/P).
// Define PWM_DEC_GLITCH_FILTER_EN to insert a 3-sample glitch filter after the synchronizer.
module pwm_duty_decoder #(
    parameter int PERIOD_W = 16,
    parameter int DUTY_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwm_in,
    output logic [DUTY_W-1:0]   duty,
    output logic [PERIOD_W-1:0] period,
    output logic                valid,
    output logic                stuck,
    output logic                overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;
    localparam int                  CNT_BITS = $clog2(DUTY_W + 1);

    logic r_sync1;
    logic r_sync2;
    logic r_lvl_q;
    logic w_lvl;
    logic w_rise;
    logic w_fall;

    // NOTE: every flop uses <= so all registers sample pre-edge values, whatever the process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_DEC_GLITCH_FILTER_EN
    logic r_hist1;
    logic r_hist2;
    logic w_agree;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist1 <= 1'b0;
            r_hist2 <= 1'b0;
        end else begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
        end
    end

    // The level only moves once three consecutive samples agree; otherwise the last level holds.
    assign w_agree = (r_sync2 == r_hist1) && (r_hist1 == r_hist2);
    assign w_lvl   = w_agree ? r_sync2 : r_lvl_q;
`else
    assign w_lvl = r_sync2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lvl_q <= 1'b0;
        end else begin
            r_lvl_q <= w_lvl;
        end
    end

    assign w_rise = w_lvl & ~r_lvl_q;
    assign w_fall = ~w_lvl & r_lvl_q;

    state_t              r_state;
    state_t              w_state_next;
    logic [PERIOD_W-1:0] r_per_cnt;
    logic [PERIOD_W-1:0] r_high_cnt;
    logic                w_timeout;
    logic                w_capture;

    // A rising edge on the saturation cycle wins, so a maximal-length period is still captured.
    assign w_timeout = (r_state != S_IDLE) && (r_per_cnt == CNT_MAX) && !w_rise;
    assign w_capture = (r_state == S_LOW) && w_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: default assigned first so no path through the case leaves the next state unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_rise) w_state_next = S_HIGH;
            S_HIGH: begin
                if (w_timeout)   w_state_next = S_IDLE;
                else if (w_fall) w_state_next = S_LOW;
            end
            S_LOW: begin
                if (w_timeout)   w_state_next = S_IDLE;
                else if (w_rise) w_state_next = S_HIGH;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per_cnt  <= '0;
            r_high_cnt <= '0;
        end else if (w_rise) begin
            r_per_cnt  <= PERIOD_W'(1);
            r_high_cnt <= PERIOD_W'(1);
        end else begin
            if (r_per_cnt != CNT_MAX) begin
                r_per_cnt <= r_per_cnt + 1'b1;
            end
            if ((r_state == S_HIGH) && !w_fall && (r_high_cnt != CNT_MAX)) begin
                r_high_cnt <= r_high_cnt + 1'b1;
            end
        end
    end

    logic                r_busy;
    logic [CNT_BITS-1:0] r_bits_left;
    logic [PERIOD_W-1:0] r_div_p;
    logic [PERIOD_W-1:0] r_rem;
    logic [DUTY_W-1:0]   r_quot;
    logic [PERIOD_W:0]   w_rem_sh;
    logic                w_qbit;
    logic [PERIOD_W-1:0] w_rem_next;
    logic [DUTY_W-1:0]   w_quot_next;
    logic                w_last;

    // Restoring division of (H<<DUTY_W) by P; since H<P the remainder starts at H and never reaches P.
    assign w_rem_sh    = {r_rem, 1'b0};
    assign w_qbit      = (w_rem_sh >= {1'b0, r_div_p});
    assign w_rem_next  = w_qbit ? (w_rem_sh[PERIOD_W-1:0] - r_div_p) : w_rem_sh[PERIOD_W-1:0];
    assign w_quot_next = {r_quot[DUTY_W-2:0], w_qbit};
    assign w_last      = r_busy && (r_bits_left == CNT_BITS'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_bits_left <= '0;
            r_div_p     <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
        end else if (w_capture && !r_busy) begin
            r_busy      <= 1'b1;
            r_bits_left <= CNT_BITS'(DUTY_W);
            r_div_p     <= r_per_cnt;
            r_rem       <= r_high_cnt;
            r_quot      <= '0;
        end else if (r_busy) begin
            r_rem       <= w_rem_next;
            r_quot      <= w_quot_next;
            r_bits_left <= r_bits_left - 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty    <= '0;
            period  <= '0;
            valid   <= 1'b0;
            stuck   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            valid   <= 1'b0;
            overrun <= w_capture && r_busy;
            if (w_timeout) begin
                duty   <= {DUTY_W{w_lvl}};
                period <= '0;
                valid  <= 1'b1;
            end else if (w_last) begin
                duty   <= w_quot_next;
                period <= r_div_p;
                valid  <= 1'b1;
            end
            if (w_timeout) begin
                stuck <= 1'b1;
            end else if (w_rise) begin
                stuck <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed testbench for pwm_duty_decoder: hand-computed duty/period, latency, overrun, timeout and reset cases.
module tb_pwm_duty_decoder;

    localparam int PERIOD_W = 16;
    localparam int DUTY_W   = 8;
`ifdef PWM_DEC_GLITCH_FILTER_EN
    localparam int EDGE_LAT = 5;
`else
    localparam int EDGE_LAT = 3;
`endif
    localparam int DIV_LAT   = EDGE_LAT + DUTY_W;
    localparam int STUCK_LAT = EDGE_LAT + (2 ** PERIOD_W) - 1;

    logic                clk    = 1'b0;
    logic                rst    = 1'b1;
    logic                pwm_in = 1'b0;
    logic [DUTY_W-1:0]   duty;
    logic [PERIOD_W-1:0] period;
    logic                valid;
    logic                stuck;
    logic                overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_ovr    = 0;
    int n_rise   = 0;
    int rise_cyc[16];
    int v_cyc[$];
    int v_duty[$];
    int v_per[$];

    pwm_duty_decoder #(
        .PERIOD_W(PERIOD_W),
        .DUTY_W  (DUTY_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .duty   (duty),
        .period (period),
        .valid  (valid),
        .stuck  (stuck),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            v_cyc.push_back(cyc);
            v_duty.push_back(int'(duty));
            v_per.push_back(int'(period));
        end
        if (overrun) n_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int vc(input int i);
        return (i >= 0 && i < v_cyc.size()) ? v_cyc[i] : -1;
    endfunction

    function automatic int vd(input int i);
        return (i >= 0 && i < v_duty.size()) ? v_duty[i] : -1;
    endfunction

    function automatic int vp(input int i);
        return (i >= 0 && i < v_per.size()) ? v_per[i] : -1;
    endfunction

    // Called at a negedge; each repetition is one rising edge followed by high/low phases.
    task automatic pwm_cycles(input int high, input int per, input int reps);
        for (int r = 0; r < reps; r++) begin
            pwm_in = 1'b1;
            rise_cyc[n_rise % 16] = cyc;
            n_rise++;
            repeat (high) @(negedge clk);
            pwm_in = 1'b0;
            repeat (per - high) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_rise = 0;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int obase;
        int limit;
        int stuck_at;

        repeat (2) @(negedge clk);
        check("rst_duty", duty, 0);
        check("rst_period", period, 0);
        check("rst_valid", valid, 0);
        check("rst_stuck", stuck, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 256/64 repeated: three captures from four rising edges
        base  = v_cyc.size();
        obase = n_ovr;
        pwm_cycles(64, 256, 4);
        repeat (20) @(negedge clk);
        check("p256_count", v_cyc.size() - base, 3);
        check("p256_duty", vd(base), 64);
        check("p256_period", vp(base), 256);
        check("p256_latency", vc(base) - rise_cyc[1], DIV_LAT);
        check("p256_spacing", vc(base + 1) - vc(base), 256);
        check("p256_last_duty", vd(v_duty.size() - 1), 64);
        check("p256_overrun", n_ovr - obase, 0);

`ifndef PWM_DEC_GLITCH_FILTER_EN
        // 3/1 single capture
        do_reset();
        base  = v_cyc.size();
        obase = n_ovr;
        pwm_cycles(1, 3, 2);
        repeat (20) @(negedge clk);
        check("p3_count", v_cyc.size() - base, 1);
        check("p3_duty", vd(base), 85);
        check("p3_period", vp(base), 3);
        check("p3_latency", vc(base) - rise_cyc[1], DIV_LAT);
        check("p3_overrun", n_ovr - obase, 0);

        // 5/2 repeated: every other capture lands while dividing
        do_reset();
        base  = v_cyc.size();
        obase = n_ovr;
        pwm_cycles(2, 5, 10);
        repeat (20) @(negedge clk);
        check("p5_count", v_cyc.size() - base, 5);
        check("p5_overrun", n_ovr - obase, 4);
        check("p5_duty", vd(v_duty.size() - 1), 102);
        check("p5_period", vp(v_per.size() - 1), 5);
`endif

        // Reset while the divider is busy
        do_reset();
        base = v_cyc.size();
        pwm_cycles(4, 8, 2);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rstdiv_count", v_cyc.size() - base, 0);
        check("rstdiv_period", period, 0);

        // Reset asserted mid-HIGH, checked before the next clock edge
        do_reset();
        base = v_cyc.size();
        pwm_cycles(64, 256, 2);
        repeat (20) @(negedge clk);
        check("pre_rst_duty", vd(base), 64);
        pwm_in = 1'b1;
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_duty", duty, 0);
        check("async_period", period, 0);
        check("async_valid", valid, 0);
        check("async_stuck", stuck, 0);
        repeat (3) @(negedge clk);
        base = v_cyc.size();
        rst  = 1'b0;
        repeat (40) @(negedge clk);
        pwm_in = 1'b0;
        repeat (200) @(negedge clk);
        check("post_rst_one_edge", v_cyc.size() - base, 0);
        pwm_in = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_count", v_cyc.size() - base, 1);
        check("post_rst_duty", vd(base), 42);
        check("post_rst_period", vp(base), 240);
        pwm_in = 1'b0;

        // One-cycle glitch inside the LOW phase of a 256/64 waveform
        do_reset();
        base   = v_cyc.size();
        pwm_in = 1'b1;
        repeat (64) @(negedge clk);
        pwm_in = 1'b0;
        repeat (64) @(negedge clk);
        pwm_in = 1'b1;
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (127) @(negedge clk);
        pwm_cycles(64, 256, 1);
        repeat (20) @(negedge clk);
`ifdef PWM_DEC_GLITCH_FILTER_EN
        check("glitch_count", v_cyc.size() - base, 1);
        check("glitch_duty", vd(base), 64);
        check("glitch_period", vp(base), 256);
`else
        check("glitch_count", v_cyc.size() - base, 2);
        check("glitch_duty", vd(base), 128);
        check("glitch_period", vp(base), 128);
        check("glitch_after_duty", vd(base + 1), 2);
        check("glitch_after_period", vp(base + 1), 128);
`endif

        // Input held low after activity until timeout
        do_reset();
        base = v_cyc.size();
        pwm_cycles(64, 256, 2);
        repeat (20) @(negedge clk);
        check("pre_stuck_duty", vd(base), 64);
        base  = v_cyc.size();
        limit = cyc + 70000;
        while (!stuck && cyc < limit) @(negedge clk);
        stuck_at = cyc;
        check("stuck_set", stuck, 1);
        check("stuck_time", stuck_at - rise_cyc[1], STUCK_LAT);
        repeat (10) @(negedge clk);
        check("stuck_valid_count", v_cyc.size() - base, 1);
        check("stuck_valid_time", vc(base), stuck_at);
        check("stuck_duty", vd(base), 0);
        check("stuck_period", vp(base), 0);
        pwm_in = 1'b1;
        repeat (EDGE_LAT - 1) @(negedge clk);
        check("stuck_hold", stuck, 1);
        @(negedge clk);
        check("stuck_clear", stuck, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_duty_decoder.md
PWM_DUTY_DECODER -- requirements
Module: pwm_duty_decoder

Interface
REQ-001 SHALL have parameter PERIOD_W, default 16, width of the period and high-time counters.
REQ-002 SHALL have parameter DUTY_W, default 8, width of the duty result (full scale 2^DUTY_W).
REQ-003 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pwm_in  input  1  PWM signal, asynchronous to clk.
REQ-006 SHALL have port duty  output  DUTY_W  last decoded duty = floor(H*2^DUTY_W/P).
REQ-007 SHALL have port period  output  PERIOD_W  last captured period P in clk cycles.
REQ-008 SHALL have port valid  output  1  one-cycle pulse when duty/period update.
REQ-009 SHALL have port stuck  output  1  level; input has had no rising edge for 2^PERIOD_W-1 cycles.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a capture is dropped.

Function
REQ-011 SHALL pass pwm_in through a 2-flop synchronizer; edges are detected on the synchronized signal against its previous registered value.
REQ-012 Measurement FSM SHALL have states IDLE, HIGH and LOW.
REQ-013 IDLE -> HIGH on a rising edge; HIGH -> LOW on a falling edge; LOW -> HIGH on a rising edge (capture); HIGH or LOW -> IDLE on timeout.
REQ-014 On every rising edge, per_cnt and high_cnt SHALL load 1. per_cnt increments every cycle; high_cnt increments only in HIGH and holds after the falling edge.
REQ-015 On a LOW->HIGH edge, the block SHALL capture P = per_cnt and H = high_cnt, both as they were before the reload. P = the number of clk cycles between rising edges; H = the number of high cycles.
REQ-016 No capture SHALL occur on the IDLE->HIGH edge; the first valid requires two rising edges.
REQ-017 Captured values SHALL feed a sequential restoring divider computing (H<<DUTY_W)/P, one quotient bit per cycle. Result width is DUTY_W, since H<P.
REQ-018 duty, period and valid SHALL update DUTY_W+1 cycles after the capture cycle.
REQ-019 If a capture occurs while the divider is busy, it SHALL be discarded and overrun SHALL pulse. The divider result in flight is unaffected.
REQ-020 Timeout: if per_cnt reaches 2^PERIOD_W-1 in HIGH or LOW, the FSM SHALL go to IDLE and stuck SHALL set. Then, without using the divider: period=0; duty = all-ones if the synchronized input is high, else 0; valid pulses once.
REQ-021 stuck SHALL clear on the next rising edge. Counters SHALL saturate and never wrap.
REQ-022 Pin-to-edge-detect latency SHALL be 3 cycles (2 sync + 1 edge register); it cancels out in P and H.

Reset
REQ-023 While rst is high, the block SHALL clear immediately: FSM=IDLE, counters=0, divider idle, duty=0, period=0, valid=0, stuck=0, overrun=0, synchronizer flops=0.
REQ-024 Reset asserted mid-measurement or mid-division SHALL abandon the operation with no valid pulse.
REQ-025 After release, the first valid SHALL need two new rising edges.

Configuration
REQ-026 Macro PWM_DEC_GLITCH_FILTER_EN, when defined, SHALL insert a 3-sample filter after the synchronizer. The filtered level changes only when 3 consecutive samples agree, so pulses of 2 cycles or less are rejected and edge latency becomes 5 cycles.
REQ-027 Without PWM_DEC_GLITCH_FILTER_EN, the synchronizer output SHALL feed edge detection directly, and every synchronized edge is honoured.

Verification
REQ-028 Period 256, high 64, repeated -> valid once per period from the 2nd rising edge, duty=64, period=256.
REQ-029 Period 3, high 1 -> duty=85, period=3; no overrun in this case.
REQ-030 Period 5, high 2 (DUTY_W=8) -> every capture while the divider is busy is dropped; overrun pulses and valid rate < 1 per period.
REQ-031 pwm_in held low for 65535 cycles after activity -> stuck=1, duty=0, period=0, single valid pulse; the next rising edge clears stuck.
REQ-032 rst pulsed mid-HIGH phase -> all outputs 0 at once; no valid until two rising edges after release.
REQ-033 1-cycle high glitch inside the LOW phase of a 256/64 waveform -> with the macro: duty=64, period=256. Without the macro: a short period is captured at the glitch.
